penalty_game_ctl: RTL and testbench

- Game sequencer for the penalty simulator; sits between the mouse path (delayed mouse position/button) and the drawing modules.
- Runs start screen -> aim -> shot flight -> result -> next shot/end; owns ball position, aim latch, goalkeeper motion and score.
- All game motion advances once per frame, on the rising edge of vblnk from the VGA timing chain.
- Outputs feed draw_rect_ctl/draw_rect (ball, keeper) and screen-select logic.

---
 rtl/penalty_game_ctl.sv | 249 ++++++++++++++++++++++++
 tb/tb_penalty_game_ctl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/penalty_game_ctl.sv
// penalty_game_ctl: penalty-shootout sequencer (IDLE/AIM/SHOT/RESULT/END) owning ball, aim, keeper and score.
// Keeper sweep is compiled only with PENALTY_KEEPER_MOVE_EN; otherwise the keeper stays at KEEPER_HOME.
module penalty_game_ctl #(
  parameter int SPOT_X        = 512,
  parameter int SPOT_Y        = 600,
  parameter int GOAL_X0       = 256,
  parameter int GOAL_X1       = 767,
  parameter int GOAL_Y0       = 100,
  parameter int GOAL_Y1       = 300,
  parameter int KEEPER_W      = 128,
  parameter int KEEPER_MIN    = 256,
  parameter int KEEPER_MAX    = 640,
  parameter int KEEPER_HOME   = 448,
  parameter int KEEPER_SPEED  = 4,
  parameter int BALL_STEP     = 8,
  parameter int RESULT_FRAMES = 60,
  parameter int MAX_SHOTS     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [2:0]  state,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [11:0] aim_x,
  output logic [11:0] aim_y,
  output logic [11:0] keeper_x,
  output logic        goal,
  output logic [3:0]  shots,
  output logic [3:0]  goals
);

  localparam int CNT_W = $clog2(RESULT_FRAMES + 1);
  localparam logic [11:0]      SPOT_X_C = 12'(SPOT_X);
  localparam logic [11:0]      SPOT_Y_C = 12'(SPOT_Y);
  localparam logic [11:0]      GX0_C    = 12'(GOAL_X0);
  localparam logic [11:0]      GX1_C    = 12'(GOAL_X1);
  localparam logic [11:0]      GY0_C    = 12'(GOAL_Y0);
  localparam logic [11:0]      GY1_C    = 12'(GOAL_Y1);
  localparam logic [12:0]      KW_C     = 13'(KEEPER_W);
  localparam logic [11:0]      KHOME_C  = 12'(KEEPER_HOME);
  localparam logic [11:0]      STEP_C   = 12'(BALL_STEP);
  localparam logic [3:0]       MAX_C    = 4'(MAX_SHOTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_FRAMES - 1);

  // Keeper geometry must be self-consistent in either build.
  if (KEEPER_HOME < KEEPER_MIN || KEEPER_HOME > KEEPER_MAX || KEEPER_SPEED < 1) begin : g_bad_keeper_cfg
    $error("penalty_game_ctl: inconsistent keeper parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_SHOT   = 3'd2,
    S_RESULT = 3'd3,
    S_END    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [11:0]      aim_x_q, aim_x_d, aim_y_q, aim_y_d;
  logic             goal_q, goal_d;
  logic [3:0]       shots_q, shots_d, goals_q, goals_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ml_s1_q, ml_s2_q, ml_s3_q, vblnk_q;
  logic             click, tick, shot_goal;
  logic [11:0]      nxt_x, nxt_y, keeper_cur;

  function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
    logic [11:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return (diff > STEP_C) ? cur + STEP_C : tgt;
    end
    diff = cur - tgt;
    return (diff > STEP_C) ? cur - STEP_C : tgt;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ml_s1_q <= 1'b0;
      ml_s2_q <= 1'b0;
      ml_s3_q <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      ml_s1_q <= mouse_left;
      ml_s2_q <= ml_s1_q;
      ml_s3_q <= ml_s2_q;
      vblnk_q <= vblnk;
    end
  end

  assign click = ml_s2_q & ~ml_s3_q;
  assign tick  = vblnk & ~vblnk_q;

  // A save needs the ball inside the keeper span [keeper_x, keeper_x+KEEPER_W).
  assign shot_goal = (aim_x_q >= GX0_C) && (aim_x_q <= GX1_C) &&
                     (aim_y_q >= GY0_C) && (aim_y_q <= GY1_C) &&
                     (({1'b0, aim_x_q} < {1'b0, keeper_cur}) ||
                      ({1'b0, aim_x_q} >= ({1'b0, keeper_cur} + KW_C)));

`ifdef PENALTY_KEEPER_MOVE_EN
  localparam logic [11:0]        KMIN_C   = 12'(KEEPER_MIN);
  localparam logic [11:0]        KMAX_C   = 12'(KEEPER_MAX);
  localparam logic signed [13:0] KMIN_S   = 14'(KEEPER_MIN);
  localparam logic signed [13:0] KMAX_S   = 14'(KEEPER_MAX);
  localparam logic signed [13:0] KSPEED_S = 14'(KEEPER_SPEED);

  logic [11:0]        keeper_q, keeper_d;
  logic               dir_q, dir_d;
  logic               keeper_home;
  logic signed [13:0] kstep;

  assign keeper_home = ((state_q == S_RESULT) && tick && (cnt_q == CNT_LAST) && (shots_q != MAX_C)) ||
                       ((state_q == S_END) && click);

  always_comb begin
    keeper_d = keeper_q;
    dir_d    = dir_q;
    kstep    = $signed({2'b00, keeper_q});
    if (keeper_home) begin
      keeper_d = KHOME_C;
      dir_d    = 1'b1;
    end else if (tick && ((state_q == S_AIM) || (state_q == S_SHOT))) begin
      kstep = dir_q ? ($signed({2'b00, keeper_q}) + KSPEED_S) : ($signed({2'b00, keeper_q}) - KSPEED_S);
      if (kstep > KMAX_S) begin
        keeper_d = KMAX_C;
        dir_d    = 1'b0;
      end else if (kstep < KMIN_S) begin
        keeper_d = KMIN_C;
        dir_d    = 1'b1;
      end else begin
        keeper_d = kstep[11:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keeper_q <= KHOME_C;
      dir_q    <= 1'b1;
    end else begin
      keeper_q <= keeper_d;
      dir_q    <= dir_d;
    end
  end

  assign keeper_cur = keeper_q;
`else
  assign keeper_cur = KHOME_C;
`endif

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    aim_x_d  = aim_x_q;
    aim_y_d  = aim_y_q;
    goal_d   = goal_q;
    shots_d  = shots_q;
    goals_d  = goals_q;
    cnt_d    = cnt_q;
    nxt_x    = step_toward(ball_x_q, aim_x_q);
    nxt_y    = step_toward(ball_y_q, aim_y_q);
    case (state_q)
      S_IDLE: if (click) state_d = S_AIM;
      S_AIM: begin
        aim_x_d = mouse_xpos;
        aim_y_d = mouse_ypos;
        if (click) state_d = S_SHOT;
      end
      S_SHOT: if (tick) begin
        ball_x_d = nxt_x;
        ball_y_d = nxt_y;
        if ((nxt_x == aim_x_q) && (nxt_y == aim_y_q)) begin
          state_d = S_RESULT;
          goal_d  = shot_goal;
          if (shots_q < MAX_C) shots_d = shots_q + 4'd1;
          if (shot_goal && (goals_q < MAX_C)) goals_d = goals_q + 4'd1;
        end
      end
      S_RESULT: if (tick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (shots_q == MAX_C) begin
            state_d = S_END;
          end else begin
            state_d  = S_AIM;
            ball_x_d = SPOT_X_C;
            ball_y_d = SPOT_Y_C;
            aim_x_d  = SPOT_X_C;
            aim_y_d  = SPOT_Y_C;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_END: if (click) begin
        state_d  = S_IDLE;
        shots_d  = '0;
        goals_d  = '0;
        goal_d   = 1'b0;
        ball_x_d = SPOT_X_C;
        ball_y_d = SPOT_Y_C;
        aim_x_d  = SPOT_X_C;
        aim_y_d  = SPOT_Y_C;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ball_x_q <= SPOT_X_C;
      ball_y_q <= SPOT_Y_C;
      aim_x_q  <= SPOT_X_C;
      aim_y_q  <= SPOT_Y_C;
      goal_q   <= 1'b0;
      shots_q  <= '0;
      goals_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      aim_x_q  <= aim_x_d;
      aim_y_q  <= aim_y_d;
      goal_q   <= goal_d;
      shots_q  <= shots_d;
      goals_q  <= goals_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state    = state_q;
  assign ball_x   = ball_x_q;
  assign ball_y   = ball_y_q;
  assign aim_x    = aim_x_q;
  assign aim_y    = aim_y_q;
  assign keeper_x = keeper_cur;
  assign goal     = goal_q;
  assign shots    = shots_q;
  assign goals    = goals_q;

endmodule

// File: tb/tb_penalty_game_ctl.sv
// Scoreboard bench for penalty_game_ctl: stimulus queues expected state transitions, a monitor checks them.
module tb_penalty_game_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic [2:0]  state;
  logic [11:0] ball_x, ball_y, aim_x, aim_y, keeper_x;
  logic        goal;
  logic [3:0]  shots, goals;

  penalty_game_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .state(state), .ball_x(ball_x), .ball_y(ball_y), .aim_x(aim_x), .aim_y(aim_y),
    .keeper_x(keeper_x), .goal(goal), .shots(shots), .goals(goals)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, bx, by, ax, ay, kx, g, sh, gl, tk, cy;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   tick_cnt = 0;
  int   cyc_cnt  = 0;
  logic [2:0] prev_st = 3'd0;

  // Keeper position is only predictable while SHOT/RESULT when the keeper is fixed.
`ifdef PENALTY_KEEPER_MOVE_EN
  localparam int KX = -1;
  function automatic int gv(input int v); return -1; endfunction
`else
  localparam int KX = 448;
  function automatic int gv(input int v); return v; endfunction
`endif

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int st, bx, by, ax, ay, kx, g, sh, gl, tk, cy);
    exp_t e;
    e.st = st; e.bx = bx; e.by = by; e.ax = ax; e.ay = ay; e.kx = kx;
    e.g = g; e.sh = sh; e.gl = gl; e.tk = tk; e.cy = cy;
    return e;
  endfunction

  // Monitor: every state change must match the next queued expectation.
  initial forever begin
    @(negedge clk);
    if (state !== prev_st) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition: state %0d -> %0d, expected none", prev_st, state);
      end else begin
        mon_e = expq.pop_front();
        chk("state", int'(state), mon_e.st);
        chk("ball_x", int'(ball_x), mon_e.bx);
        chk("ball_y", int'(ball_y), mon_e.by);
        chk("aim_x", int'(aim_x), mon_e.ax);
        chk("aim_y", int'(aim_y), mon_e.ay);
        chk("keeper_x", int'(keeper_x), mon_e.kx);
        chk("goal", int'(goal), mon_e.g);
        chk("shots", int'(shots), mon_e.sh);
        chk("goals", int'(goals), mon_e.gl);
        chk("tick_index", tick_cnt, mon_e.tk);
        chk("cycle_index", cyc_cnt, mon_e.cy);
      end
      prev_st = state;
    end
  end

  task automatic do_tick();
    @(negedge clk);
    vblnk = 1'b1;
    tick_cnt++;
    @(negedge clk);
    vblnk = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic click(input bit chg, input exp_t e, input int hold);
    @(negedge clk);
    if (chg) begin
      e.cy = cyc_cnt + 3;
      expq.push_back(e);
    end
    mouse_left = 1'b1;
    repeat (hold) @(negedge clk);
    mouse_left = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One full shot: aim, fly n ticks, hold RESULT 60 ticks; ignored clicks in SHOT and RESULT.
  task automatic shoot(input int ax, input int ay, input int n, input int g,
                       input int sh, input int gl, input bit last);
    mouse_xpos = 12'(ax);
    mouse_ypos = 12'(ay);
    click(1'b1, mk(2, 512, 600, ax, ay, KX, -1, sh - 1, -1, -1, 0), 4);
    expq.push_back(mk(3, ax, ay, ax, ay, KX, gv(g), sh, gv(gl), tick_cnt + n, -1));
    ticks(n / 2);
    click(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4);
    ticks(n - n / 2);
    if (last)
      expq.push_back(mk(4, ax, ay, ax, ay, KX, gv(g), sh, gv(gl), tick_cnt + 60, -1));
    else
      expq.push_back(mk(1, 512, 600, 512, 600, 448, gv(g), sh, gv(gl), tick_cnt + 60, -1));
    ticks(30);
    click(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4);
    ticks(30);
  endtask

`ifdef PENALTY_KEEPER_MOVE_EN
  task automatic keeper_sweep();
    int kp, nx;
    bit kd;
    kp = 448;
    kd = 1'b1;
    for (int i = 0; i < 250; i++) begin
      do_tick();
      nx = kd ? kp + 4 : kp - 4;
      if (nx > 640) begin kp = 640; kd = 1'b0; end
      else if (nx < 256) begin kp = 256; kd = 1'b1; end
      else kp = nx;
      chk("keeper_sweep", int'(keeper_x), kp);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    vblnk      = 1'b0;
    mouse_left = 1'b0;
    mouse_xpos = 12'd0;
    mouse_ypos = 12'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_ball_x", int'(ball_x), 512);
    chk("rst_ball_y", int'(ball_y), 600);
    chk("rst_aim_x", int'(aim_x), 512);
    chk("rst_aim_y", int'(aim_y), 600);
    chk("rst_keeper", int'(keeper_x), 448);
    chk("rst_goal", int'(goal), 0);
    chk("rst_shots", int'(shots), 0);
    chk("rst_goals", int'(goals), 0);

    // Held button: exactly one click, IDLE -> AIM on the 3rd edge, no SHOT.
    click(1'b1, mk(1, 512, 600, 512, 600, 448, 0, 0, 0, -1, 0), 12);
`ifdef PENALTY_KEEPER_MOVE_EN
    keeper_sweep();
    expq.push_back(mk(2, 512, 600, 0, 0, -1, -1, 0, -1, -1, -1));
`endif

    shoot(300, 200, 50, 1, 1, 1, 1'b0);
    shoot(500, 200, 50, 0, 2, 1, 1'b0);
    shoot(900, 200, 50, 0, 3, 1, 1'b0);
    shoot(767, 300, 38, 1, 4, 2, 1'b0);
    shoot(512, 600, 1, 0, 5, 2, 1'b1);

    click(1'b1, mk(0, 512, 600, 512, 600, 448, 0, 0, 0, -1, 0), 4);

    // Second game, then asynchronous reset in the middle of a flight.
    click(1'b1, mk(1, 512, 600, 512, 600, 448, 0, 0, 0, -1, 0), 4);
    shoot(512, 600, 1, 0, 1, 0, 1'b0);
    mouse_xpos = 12'd300;
    mouse_ypos = 12'd200;
    click(1'b1, mk(2, 512, 600, 300, 200, KX, -1, 1, -1, -1, 0), 4);
    ticks(5);
    chk("pre_rst_ball_y", int'(ball_y), 560);
    expq.push_back(mk(0, 512, 600, 512, 600, 448, 0, 0, 0, -1, -1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_ball_x", int'(ball_x), 512);
    chk("async_rst_ball_y", int'(ball_y), 600);
    chk("async_rst_shots", int'(shots), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_transitions: got %0d outstanding expected 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
